// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode sequencer: owns the program store, fetches the
// word at pc_addr and decodes it into PC-control and datapath fields.
// Each instruction runs FETCH -> DECODE -> EXEC, so the PC moves once per
// instruction (ps is non-HOLD only in EXEC).
module instr_fetch_decode #(
    parameter int ADDR_WIDTH  = 6,
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH       = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc_addr,
    input  logic                   run,
    input  logic                   prog_we,
    input  logic [ADDR_WIDTH-1:0]  prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   d_nonzero,
    output logic [1:0]             ps,
    output logic [1:0]             bc,
    output logic [3:0]             aa,
    output logic [3:0]             ba,
    output logic [3:0]             da,
    output logic [3:0]             alu_op,
    output logic                   reg_we,
    output logic                   busy,
    output logic                   halted
);

    // PC update styles
    localparam logic [1:0] PS_HOLD = 2'd0;
    localparam logic [1:0] PS_INC  = 2'd1;
    localparam logic [1:0] PS_REL  = 2'd2;
    localparam logic [1:0] PS_ABS  = 2'd3;

    // Branch conditions
    localparam logic [1:0] BC_ZERO   = 2'd0;
    localparam logic [1:0] BC_NZERO  = 2'd1;
    localparam logic [1:0] BC_ALWAYS = 2'd3;

    // Opcodes above the ALU range
    localparam logic [3:0] OP_LAST_ALU = 4'hB;
    localparam logic [3:0] OP_BZ       = 4'hC;
    localparam logic [3:0] OP_BNZ      = 4'hD;
    localparam logic [3:0] OP_JMP      = 4'hE;
    localparam logic [3:0] OP_HALT     = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
    logic [INSTR_WIDTH-1:0] r_rdata;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic [3:0]             w_op;
    logic                   w_store_open;

    assign w_op         = r_ir[15:12];
    assign w_store_open = (r_state == S_IDLE) || (r_state == S_HALT);

    // Program store write port; only open while no program is executing
    always_ff @(posedge clk) begin
        if (prog_we && w_store_open) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // Program store read port; read issued in FETCH, data usable in DECODE
    always_ff @(posedge clk) begin
        if (r_state == S_FETCH) begin
            r_rdata <= r_mem[pc_addr];
        end
    end

    // Instruction register loaded at the end of DECODE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir <= '0;
        end else if (r_state == S_DECODE) begin
            r_ir <= r_rdata;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; HALT is left only through reset
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = (w_op == OP_HALT) ? S_HALT : S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode; control fields are active only in EXEC
    always_comb begin
        ps     = PS_HOLD;
        bc     = BC_ALWAYS;
        alu_op = '0;
        reg_we = 1'b0;
        if (r_state == S_EXEC) begin
            if (w_op <= OP_LAST_ALU) begin
                ps     = PS_INC;
                alu_op = w_op;
                reg_we = 1'b1;
            end else begin
                case (w_op)
                    OP_BZ: begin
                        if (!d_nonzero) begin
                            ps = PS_REL;
                            bc = BC_ZERO;
                        end else begin
                            ps = PS_INC;
                        end
                    end
                    OP_BNZ: begin
                        if (d_nonzero) begin
                            ps = PS_REL;
                            bc = BC_NZERO;
                        end else begin
                            ps = PS_INC;
                        end
                    end
                    OP_JMP:  ps = PS_ABS;
                    OP_HALT: ps = PS_HOLD;
                    default: ps = PS_HOLD;
                endcase
            end
        end
    end

    assign aa     = r_ir[7:4];
    assign ba     = r_ir[3:0];
    assign da     = r_ir[11:8];
    assign busy   = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
    assign halted = (r_state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode with a small program-counter model.
// Stimulus pushes the expected EXEC-cycle fields; the monitor pops them on
// every third consecutive busy cycle and checks HOLD controls elsewhere.
module tb_instr_fetch_decode;

    typedef struct packed {
        logic [1:0] ps;
        logic [1:0] bc;
        logic [3:0] aa;
        logic [3:0] ba;
        logic [3:0] da;
        logic [3:0] alu_op;
        logic       reg_we;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        prog_we = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        d_nonzero = 1'b0;
    logic [5:0]  pc_addr;
    logic [5:0]  jmp_target = 6'd42;
    logic [1:0]  ps;
    logic [1:0]  bc;
    logic [3:0]  aa;
    logic [3:0]  ba;
    logic [3:0]  da;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        busy;
    logic        halted;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          phase = 0;
    logic        mon_en = 1'b0;

    instr_fetch_decode #(
        .ADDR_WIDTH (6),
        .INSTR_WIDTH(16),
        .DEPTH      (64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_addr  (pc_addr),
        .run      (run),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .d_nonzero(d_nonzero),
        .ps       (ps),
        .bc       (bc),
        .aa       (aa),
        .ba       (ba),
        .da       (da),
        .alu_op   (alu_op),
        .reg_we   (reg_we),
        .busy     (busy),
        .halted   (halted)
    );

    // Clock
    always #5 clk = ~clk;

    // Program counter model: REL target is pc + 1 + signed {aa,ba}
    always @(posedge clk) begin
        logic [7:0] rel;
        rel = {2'b00, pc_addr} + 8'd1 + {aa, ba};
        if (reset) pc_addr <= '0;
        else begin
            case (ps)
                2'd1: pc_addr <= pc_addr + 6'd1;
                2'd2: pc_addr <= rel[5:0];
                2'd3: pc_addr <= jmp_target;
                default: pc_addr <= pc_addr;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: EXEC is the third busy cycle of each instruction
    always @(negedge clk) begin
        if (mon_en) begin
            if (!busy) phase = 0;
            else phase = (phase == 3) ? 1 : phase + 1;
            if (phase == 3) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL exec_unexpected: got EXEC with empty scoreboard at %0t", $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("exec_fields", {11'd0, ps, bc, aa, ba, da, alu_op, reg_we}, {11'd0, e});
                end
            end else begin
                chk("hold_ctl", {23'd0, ps, bc, alu_op, reg_we}, {23'd0, 2'd0, 2'd3, 4'd0, 1'b0});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        prog_we = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [5:0] a, input logic [15:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic push(input logic [1:0] p, input logic [1:0] b, input logic [3:0] a,
                        input logic [3:0] bb, input logic [3:0] d, input logic [3:0] op,
                        input logic we);
        exp_t e;
        e = '{ps: p, bc: b, aa: a, ba: bb, da: d, alu_op: op, reg_we: we};
        q.push_back(e);
    endtask

    // Runs one instruction and stops in the following FETCH, checking the PC
    task automatic run_one(input string nm, input logic [5:0] exp_pc);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk(nm, {26'd0, pc_addr}, {26'd0, exp_pc});
        chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    // Directed stimulus
    initial begin
        do_reset();
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_state", {9'd0, ps, bc, aa, ba, da, alu_op, reg_we, busy, halted},
            {9'd0, 2'd0, 2'd3, 16'd0, 1'b0, 1'b0, 1'b0});

        // ALU op, written in the same cycle as run
        push(2'd1, 2'd3, 4'd3, 4'd4, 4'd2, 4'd1, 1'b1);
        prog_we = 1'b1; prog_addr = 6'd0; prog_data = 16'h1234; run = 1'b1;
        tick();
        prog_we = 1'b0; run = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("t1_pc", {26'd0, pc_addr}, 32'd1);
        chk("t1_fields_kept", {20'd0, aa, ba, da}, {20'd0, 12'h342});
        do_reset();

        // BZ taken wraps backwards, then not taken
        load(6'd0, 16'hC2FE);
        d_nonzero = 1'b0;
        push(2'd2, 2'd0, 4'hF, 4'hE, 4'd2, 4'd0, 1'b0);
        run_one("t2_bz_taken_pc", 6'd63);
        do_reset();
        d_nonzero = 1'b1;
        push(2'd1, 2'd3, 4'hF, 4'hE, 4'd2, 4'd0, 1'b0);
        run_one("t2_bz_not_taken_pc", 6'd1);
        do_reset();

        // BNZ taken, BNZ not taken, JMP
        load(6'd0, 16'hD100);
        d_nonzero = 1'b1;
        push(2'd2, 2'd1, 4'd0, 4'd0, 4'd1, 4'd0, 1'b0);
        run_one("t3_bnz_taken_pc", 6'd1);
        do_reset();
        d_nonzero = 1'b0;
        push(2'd1, 2'd3, 4'd0, 4'd0, 4'd1, 4'd0, 1'b0);
        run_one("t3_bnz_not_taken_pc", 6'd1);
        do_reset();
        load(6'd0, 16'hE050);
        push(2'd3, 2'd3, 4'd5, 4'd0, 4'd0, 4'd0, 1'b0);
        run_one("t3_jmp_pc", 6'd42);
        do_reset();

        // HALT: stays halted even with run high; store writable in HALT
        load(6'd0, 16'hF000);
        push(2'd0, 2'd3, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        tick();
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t4_halt", {28'd0, halted, busy, ps}, {28'd0, 1'b1, 1'b0, 2'd0});
            chk("t4_halt_pc", {26'd0, pc_addr}, 32'd0);
        end
        run = 1'b0;
        load(6'd0, 16'h2345);
        do_reset();
        @(negedge clk);
        chk("t4_ir_cleared", {20'd0, aa, ba, da}, 32'd0);
        push(2'd1, 2'd3, 4'd4, 4'd5, 4'd3, 4'd2, 1'b1);
        run_one("t4_readback_pc", 6'd1);
        do_reset();

        // Writes while busy are ignored
        load(6'd0, 16'h1234);
        push(2'd1, 2'd3, 4'd3, 4'd4, 4'd2, 4'd1, 1'b1);
        run = 1'b1;
        tick();
        run = 1'b0;
        prog_we = 1'b1; prog_addr = 6'd0; prog_data = 16'hFFFF;
        tick();
        tick();
        tick();
        prog_we = 1'b0;
        @(negedge clk);
        chk("t5_pc", {26'd0, pc_addr}, 32'd1);
        do_reset();
        push(2'd1, 2'd3, 4'd3, 4'd4, 4'd2, 4'd1, 1'b1);
        run_one("t5_rerun_pc", 6'd1);
        do_reset();

        // Reset during EXEC
        push(2'd1, 2'd3, 4'd3, 4'd4, 4'd2, 4'd1, 1'b1);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_reset_exec", {28'd0, ps, reg_we, busy}, 32'd0);
        chk("t6_reset_idle", {31'd0, halted}, 32'd0);
        chk("t6_reset_pc", {26'd0, pc_addr}, 32'd0);
        reset = 1'b0;
        push(2'd1, 2'd3, 4'd3, 4'd4, 4'd2, 4'd1, 1'b1);
        run_one("t6_rerun_pc", 6'd1);
        do_reset();

        tick();
        tick();
        chk("sb_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
